serial_feeder: RTL

//  Parallel-to-serial front end that feeds the two-equal-bits Mealy detector.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_feeder.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial feeder.
// Holds the FSM state encoding and the counter width function.
package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_feeder.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// one bit per clock out with valid/last qualifiers, no gap between words.
module serial_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             at_last;
  logic             accept;
  logic             shifting;
  logic             drain;
  logic             in_head;
  logic [WIDTH-1:0] in_rest;
  logic             sreg_head;
  logic [WIDTH-1:0] sreg_rest;

  // The next bit always sits at the head end of sreg.
  assign in_head   = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign in_rest   = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
  assign sreg_head = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_rest = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

  assign at_last  = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign in_ready = !rst && ((state_q == S_IDLE) || at_last);
  assign accept   = in_valid && in_ready;
  assign shifting = (state_q == S_SHIFT) && !at_last;
  assign drain    = at_last && !accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (1'b1)
      accept: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        sreg_d  = in_rest;
        out_d   = in_head;
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      shifting: begin
        cnt_d   = cnt_q + CW'(1);
        sreg_d  = sreg_rest;
        out_d   = sreg_head;
        last_d  = (cnt_q + CW'(1)) == LAST;
      end
      drain: begin
        state_d = S_IDLE;
        out_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign ser_out   = out_q;
  assign ser_valid = valid_q;
  assign ser_last  = last_q;

endmodule
